// File: rtl/trap_stall_ctrl.sv
// trap_stall_ctrl
//   Pipeline stall arbitration plus trap/mret sequencing for the core.
//   Stall vector is purely combinational; trap entry and mret run through a
//   small registered FSM, and trap info is captured on the accepting edge.
//
// Ports
//   clk_i, n_rst_i            clock, async active-low reset
//   exception_i[6:0]          {mis_load, mis_store, illegal, mis_inst, ebreak, ecall, mret}
//   pc_i, inst_i              PC / instruction word of the excepting instruction
//   if_pc_i                   IF-stage PC, EPC for interrupts
//   stallreq_i                per-stage stall requests (bit 0 = IF)
//   halt_i                    debug halt
//   mstatus_ie_i, irq_en_i, irq_pend_i   global enable, mie, mip
//   mtvec_i, epc_i            trap vector, mret target
//   stall_o                   bit 0 = PC, bit k+1 = stage k pipeline register
//   flush_o, redirect_o, new_pc_o        PC control
//   set_cause_o, set_epc_o, set_mtval_o  CSR write strobes
//   trap_cause_o, ie_type_o, epc_o, mtval_o  CSR write data (held)
//   mstatus_ie_clear_o, mstatus_ie_set_o     MIE strobes
module trap_stall_ctrl #(
    parameter int              XLEN          = 32,
    parameter int              NUM_STAGES    = 5,
    parameter int              NUM_LOCAL_IRQ = 4,
    parameter logic [XLEN-1:0] REBOOT_ADDR   = '0
) (
    input  logic                     clk_i,
    input  logic                     n_rst_i,
    input  logic [6:0]               exception_i,
    input  logic [XLEN-1:0]          pc_i,
    input  logic [XLEN-1:0]          inst_i,
    input  logic [XLEN-1:0]          if_pc_i,
    input  logic [NUM_STAGES-1:0]    stallreq_i,
    input  logic                     halt_i,
    input  logic                     mstatus_ie_i,
    input  logic [16+NUM_LOCAL_IRQ-1:0] irq_en_i,
    input  logic [16+NUM_LOCAL_IRQ-1:0] irq_pend_i,
    input  logic [XLEN-1:0]          mtvec_i,
    input  logic [XLEN-1:0]          epc_i,
    output logic [NUM_STAGES:0]      stall_o,
    output logic                     flush_o,
    output logic                     redirect_o,
    output logic [XLEN-1:0]          new_pc_o,
    output logic                     set_cause_o,
    output logic                     set_epc_o,
    output logic                     set_mtval_o,
    output logic [4:0]               trap_cause_o,
    output logic                     ie_type_o,
    output logic [XLEN-1:0]          epc_o,
    output logic [XLEN-1:0]          mtval_o,
    output logic                     mstatus_ie_clear_o,
    output logic                     mstatus_ie_set_o
);

    localparam int IRQ_W = 16 + NUM_LOCAL_IRQ;

    typedef enum logic [1:0] {ST_RESET, ST_RUN, ST_TRAP, ST_MRET} state_t;

    typedef struct packed {
        logic            ie;
        logic [4:0]      cause;
        logic [XLEN-1:0] epc;
        logic [XLEN-1:0] mtval;
        logic            set_mtval;
    } trap_info_t;

    // ---------------- stall arbitration ----------------
    logic [NUM_STAGES:0] stall_raw;
    logic                stall_busy;

    // The highest requesting stage freezes itself and everything upstream.
    always_comb begin
        stall_raw = '0;
        if (halt_i) begin
            stall_raw = {1'b0, {NUM_STAGES{1'b1}}};
        end else begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                if (stallreq_i[k]) begin
                    for (int j = 0; j <= NUM_STAGES; j++) begin
                        if (j <= k + 1) stall_raw[j] = 1'b1;
                    end
                end
            end
        end
    end

    assign stall_o    = n_rst_i ? stall_raw : '0;
    assign stall_busy = halt_i | (|stallreq_i);

    // ---------------- interrupt priority ----------------
    logic [IRQ_W-1:0] ip;
    logic             irq_vld;
    logic [4:0]       irq_cause;

    assign ip = irq_en_i & irq_pend_i & {IRQ_W{mstatus_ie_i}};

    // Assign from lowest priority upward so later hits override.
    always_comb begin
        irq_vld   = 1'b0;
        irq_cause = '0;
        for (int i = IRQ_W - 1; i >= 16; i--) begin
            if (ip[i]) begin
                irq_vld   = 1'b1;
                irq_cause = 5'(i);
            end
        end
        if (ip[7])  begin irq_vld = 1'b1; irq_cause = 5'd7;  end
        if (ip[3])  begin irq_vld = 1'b1; irq_cause = 5'd3;  end
        if (ip[11]) begin irq_vld = 1'b1; irq_cause = 5'd11; end
    end

    // ---------------- exception priority ----------------
    logic            exc_vld;
    logic [4:0]      exc_cause;
    logic [XLEN-1:0] exc_mtval;
    logic            exc_set_mtval;

    always_comb begin
        exc_vld       = |exception_i[6:1];
        exc_cause     = '0;
        exc_mtval     = '0;
        exc_set_mtval = 1'b0;
        if (exception_i[3]) begin
            exc_cause = 5'd0;  exc_mtval = pc_i;   exc_set_mtval = 1'b1;
        end else if (exception_i[4]) begin
            exc_cause = 5'd2;  exc_mtval = inst_i; exc_set_mtval = 1'b1;
        end else if (exception_i[2]) begin
            exc_cause = 5'd3;  exc_mtval = pc_i;   exc_set_mtval = 1'b1;
        end else if (exception_i[5]) begin
            exc_cause = 5'd6;  exc_mtval = pc_i;   exc_set_mtval = 1'b1;
        end else if (exception_i[6]) begin
            exc_cause = 5'd4;  exc_mtval = pc_i;   exc_set_mtval = 1'b1;
        end else if (exception_i[1]) begin
            exc_cause = 5'd11;
        end
    end

    // Interrupts win over exceptions; mtval is only written for exceptions.
    trap_info_t info_d, info_q;

    always_comb begin
        info_d = '0;
        if (irq_vld) begin
            info_d.ie    = 1'b1;
            info_d.cause = irq_cause;
            info_d.epc   = if_pc_i;
        end else begin
            info_d.cause     = exc_cause;
            info_d.epc       = pc_i;
            info_d.mtval     = exc_mtval;
            info_d.set_mtval = exc_set_mtval;
        end
    end

    // ---------------- FSM ----------------
    state_t state_q, state_d;
    logic   take_trap, take_mret;

    // Events seen while stalled are dropped, not queued: the source must
    // still be asserting when the stall releases.
    assign take_trap = (state_q == ST_RUN) && (irq_vld || exc_vld) && !stall_busy;
    assign take_mret = (state_q == ST_RUN) && exception_i[0] && !stall_busy && !take_trap;

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            state_q <= ST_RESET;
            info_q  <= '0;
        end else begin
            state_q <= state_d;
            if (take_trap) info_q <= info_d;
        end
    end

    logic [XLEN-1:0] vec_base;
    assign vec_base = {mtvec_i[XLEN-1:2], 2'b00};

    always_comb begin
        state_d            = state_q;
        flush_o            = 1'b0;
        redirect_o         = 1'b0;
        new_pc_o           = '0;
        set_cause_o        = 1'b0;
        set_epc_o          = 1'b0;
        set_mtval_o        = 1'b0;
        mstatus_ie_clear_o = 1'b0;
        mstatus_ie_set_o   = 1'b0;
        case (state_q)
            ST_RESET: begin
                state_d    = ST_RUN;
                redirect_o = 1'b1;
                new_pc_o   = REBOOT_ADDR;
            end
            ST_RUN: begin
                if (take_trap)      state_d = ST_TRAP;
                else if (take_mret) state_d = ST_MRET;
            end
            ST_TRAP: begin
                state_d            = ST_RUN;
                set_cause_o        = 1'b1;
                set_epc_o          = 1'b1;
                set_mtval_o        = info_q.set_mtval;
                mstatus_ie_clear_o = 1'b1;
                redirect_o         = info_q.ie;
                flush_o            = !info_q.ie;
                new_pc_o           = vec_base;
                if (mtvec_i[0] && info_q.ie)
                    new_pc_o = vec_base + {{(XLEN-7){1'b0}}, info_q.cause, 2'b00};
            end
            ST_MRET: begin
                state_d          = ST_RUN;
                flush_o          = 1'b1;
                new_pc_o         = epc_i;
                mstatus_ie_set_o = 1'b1;
            end
            default: state_d = ST_RESET;
        endcase
    end

    assign trap_cause_o = info_q.cause;
    assign ie_type_o    = info_q.ie;
    assign epc_o        = info_q.epc;
    assign mtval_o      = info_q.mtval;

endmodule

// File: tb/tb_trap_stall_ctrl.sv
module tb_trap_stall_ctrl;

    localparam int NS = 5;
    localparam int NL = 4;
    localparam int IW = 16 + NL;
    localparam logic [31:0] REBOOT = 32'h0000_0000;

    logic          clk_i = 1'b0;
    logic          n_rst_i;
    logic [6:0]    exception_i;
    logic [31:0]   pc_i, inst_i, if_pc_i, mtvec_i, epc_i;
    logic [NS-1:0] stallreq_i;
    logic          halt_i, mstatus_ie_i;
    logic [IW-1:0] irq_en_i, irq_pend_i;
    logic [NS:0]   stall_o;
    logic          flush_o, redirect_o, set_cause_o, set_epc_o, set_mtval_o;
    logic [31:0]   new_pc_o, epc_o, mtval_o;
    logic [4:0]    trap_cause_o;
    logic          ie_type_o, mstatus_ie_clear_o, mstatus_ie_set_o;

    trap_stall_ctrl #(.XLEN(32), .NUM_STAGES(NS), .NUM_LOCAL_IRQ(NL), .REBOOT_ADDR(REBOOT)) dut (
        .clk_i(clk_i), .n_rst_i(n_rst_i), .exception_i(exception_i), .pc_i(pc_i),
        .inst_i(inst_i), .if_pc_i(if_pc_i), .stallreq_i(stallreq_i), .halt_i(halt_i),
        .mstatus_ie_i(mstatus_ie_i), .irq_en_i(irq_en_i), .irq_pend_i(irq_pend_i),
        .mtvec_i(mtvec_i), .epc_i(epc_i), .stall_o(stall_o), .flush_o(flush_o),
        .redirect_o(redirect_o), .new_pc_o(new_pc_o), .set_cause_o(set_cause_o),
        .set_epc_o(set_epc_o), .set_mtval_o(set_mtval_o), .trap_cause_o(trap_cause_o),
        .ie_type_o(ie_type_o), .epc_o(epc_o), .mtval_o(mtval_o),
        .mstatus_ie_clear_o(mstatus_ie_clear_o), .mstatus_ie_set_o(mstatus_ie_set_o));

    always #5 clk_i = ~clk_i;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: phase 0=reset cycle, 1=running, 2=trap cycle, 3=mret cycle
    int          m_phase;
    int          m_cause;
    bit          m_ie;
    logic [31:0] m_epc, m_mtval;
    bit          m_setmtval;
    bit          m_mtval_known;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_stall();
        int top;
        top = -1;
        if (!n_rst_i) return 32'd0;
        if (halt_i) return (32'd1 << NS) - 1;
        for (int k = 0; k < NS; k++) if (stallreq_i[k]) top = k;
        if (top < 0) return 32'd0;
        return (32'd1 << (top + 2)) - 1;
    endfunction

    // Returns the winning interrupt index, or -1.
    function automatic int pick_irq();
        int order[$];
        logic [IW-1:0] p;
        p = irq_en_i & irq_pend_i;
        if (!mstatus_ie_i) return -1;
        order = '{11, 3, 7};
        for (int i = 16; i < IW; i++) order.push_back(i);
        foreach (order[n]) if (p[order[n]]) return order[n];
        return -1;
    endfunction

    // Exception priority table: exception_i bit, cause, mtval source (0 none,1 pc,2 inst)
    function automatic int pick_exc(output int cause, output int src);
        int bits[6]  = '{3, 4, 2, 5, 6, 1};
        int cz[6]    = '{0, 2, 3, 6, 4, 11};
        int sz[6]    = '{1, 2, 1, 1, 1, 0};
        cause = 0; src = 0;
        for (int n = 0; n < 6; n++) if (exception_i[bits[n]]) begin
            cause = cz[n]; src = sz[n]; return 1;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_cause = 0; m_ie = 0; m_epc = 0; m_mtval = 0;
        m_setmtval = 0; m_mtval_known = 1;
    endtask

    // Advance the model using the inputs present at the coming edge.
    task automatic model_edge();
        int irq, ec, src, hit;
        bit busy;
        busy = halt_i || (stallreq_i != 0);
        irq  = pick_irq();
        hit  = pick_exc(ec, src);
        if (m_phase != 1) begin
            m_phase = 1;
        end else if (!busy && (irq >= 0 || hit != 0)) begin
            m_phase = 2;
            if (irq >= 0) begin
                m_ie = 1; m_cause = irq; m_epc = if_pc_i; m_setmtval = 0; m_mtval_known = 0;
            end else begin
                m_ie = 0; m_cause = ec; m_epc = pc_i; m_setmtval = (src != 0);
                m_mtval_known = (src != 0);
                m_mtval = (src == 2) ? inst_i : pc_i;
            end
        end else if (!busy && exception_i[0]) begin
            m_phase = 3;
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] npc;
        bit rd, fl, sc, se, sm, ic, is_;
        rd = 0; fl = 0; sc = 0; se = 0; sm = 0; ic = 0; is_ = 0; npc = 0;
        if (!n_rst_i || m_phase == 0) begin
            rd = 1; npc = REBOOT;
        end else if (m_phase == 2) begin
            sc = 1; se = 1; ic = 1; sm = m_setmtval;
            rd = m_ie; fl = !m_ie;
            npc = (mtvec_i & ~32'd3) + ((mtvec_i[0] && m_ie) ? 32'(m_cause) * 4 : 32'd0);
        end else if (m_phase == 3) begin
            fl = 1; is_ = 1; npc = epc_i;
        end
        chk({tag, ".stall"},     32'(stall_o),            exp_stall());
        chk({tag, ".redirect"},  32'(redirect_o),         32'(rd));
        chk({tag, ".flush"},     32'(flush_o),            32'(fl));
        chk({tag, ".new_pc"},    new_pc_o,                npc);
        chk({tag, ".set_cause"}, 32'(set_cause_o),        32'(sc));
        chk({tag, ".set_epc"},   32'(set_epc_o),          32'(se));
        chk({tag, ".set_mtval"}, 32'(set_mtval_o),        32'(sm));
        chk({tag, ".ie_clr"},    32'(mstatus_ie_clear_o), 32'(ic));
        chk({tag, ".ie_set"},    32'(mstatus_ie_set_o),   32'(is_));
        chk({tag, ".cause"},     32'(trap_cause_o),       32'(m_cause));
        chk({tag, ".ie_type"},   32'(ie_type_o),          32'(m_ie));
        chk({tag, ".epc"},       epc_o,                   m_epc);
        if (m_mtval_known) chk({tag, ".mtval"}, mtval_o, m_mtval);
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clk_i);
        #1;
        check_all(tag);
    endtask

    task automatic idle();
        exception_i = 0; stallreq_i = 0; halt_i = 0;
        irq_en_i = 0; irq_pend_i = 0; mstatus_ie_i = 0;
    endtask

    initial begin
        n_rst_i = 0; idle(); pc_i = 0; inst_i = 0; if_pc_i = 0;
        mtvec_i = 32'h8000_0001; epc_i = 0;
        model_reset();

        // reset state: stall forced low even with requests up
        stallreq_i = 5'b11111; halt_i = 1;
        #12; check_all("rst");
        stallreq_i = 0; halt_i = 0;
        @(negedge clk_i); n_rst_i = 1; #1;
        check_all("reboot");
        step("run0");

        // combinational stall vector
        stallreq_i = 5'b00100; #1; check_all("stall_s2");
        chk("stall_s2_const", 32'(stall_o), 32'h0F);
        halt_i = 1; #1; check_all("stall_halt");
        chk("stall_halt_const", 32'(stall_o), 32'h1F);
        halt_i = 0; stallreq_i = 5'b10000; #1; check_all("stall_s4");
        chk("stall_s4_const", 32'(stall_o), 32'h3F);
        stallreq_i = 0; #1;

        // interrupt 7 beats local 17, vectored
        mstatus_ie_i = 1; irq_en_i = (1 << 7) | (1 << 17); irq_pend_i = irq_en_i;
        if_pc_i = 32'h100; pc_i = 32'h300;
        step("irq");
        chk("irq_npc_const", new_pc_o, 32'h8000_001C);
        chk("irq_cause_const", 32'(trap_cause_o), 32'd7);
        idle(); step("irq_ret");

        // illegal beats ebreak; exceptions not vectored
        exception_i = 7'b001_0100; inst_i = 32'hFFFF_FFFF; pc_i = 32'h44;
        step("illegal");
        chk("ill_mtval_const", mtval_o, 32'hFFFF_FFFF);
        chk("ill_npc_const", new_pc_o, 32'h8000_0000);
        idle(); step("ill_ret");

        // ecall deferred by stall on stage 3
        exception_i = 7'b000_0010; stallreq_i = 5'b01000; pc_i = 32'h88;
        step("ecall_st0"); step("ecall_st1"); step("ecall_st2");
        stallreq_i = 0;
        step("ecall");
        chk("ecall_cause_const", 32'(trap_cause_o), 32'd11);
        idle(); step("ecall_ret");

        // mret
        exception_i = 7'b000_0001; epc_i = 32'h204;
        step("mret");
        idle(); step("mret_ret");

        // mret with interrupt: trap wins
        exception_i = 7'b000_0001; mstatus_ie_i = 1; irq_en_i = 1 << 11; irq_pend_i = 1 << 11;
        mtvec_i = 32'h0000_1000;
        step("mret_irq");
        idle(); step("mret_irq_ret");

        // async reset during TRAP
        exception_i = 7'b100_0000; pc_i = 32'hFFFF_FFFC;
        step("misload");
        n_rst_i = 0; #1; model_reset();
        check_all("rst_mid_trap");
        idle();
        @(negedge clk_i); n_rst_i = 1; #1;
        check_all("reboot2");
        step("run2");

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            exception_i  = ($urandom_range(0, 2) == 0) ? 7'($urandom) : 7'd0;
            stallreq_i   = ($urandom_range(0, 2) == 0) ? NS'($urandom) : '0;
            halt_i       = ($urandom_range(0, 9) == 0);
            mstatus_ie_i = 1'($urandom);
            irq_en_i     = IW'($urandom);
            irq_pend_i   = ($urandom_range(0, 2) == 0) ? IW'($urandom) : '0;
            pc_i = $urandom; inst_i = $urandom; if_pc_i = $urandom;
            mtvec_i = $urandom; epc_i = $urandom;
            #1; check_all("rnd_comb");
            step("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
